// File: rtl/srrc_symbol_upsampler_pkg.sv
// srrc_symbol_upsampler_pkg: shared symbol codes, FSM states and the bit-to-symbol map
package srrc_symbol_upsampler_pkg;
  localparam logic [1:0] SYM_POS  = 2'b01;
  localparam logic [1:0] SYM_NEG  = 2'b11;
  localparam logic [1:0] SYM_ZERO = 2'b00;
  typedef enum logic [1:0] {IDLE, RUN, FLUSH} state_t;
  function automatic logic [1:0] map_sym(input logic b);
    return b ? SYM_NEG : SYM_POS;
  endfunction
endpackage

// File: rtl/srrc_symbol_upsampler_if.sv
// srrc_symbol_upsampler_if: serial bit stream valid/ready handshake
interface srrc_symbol_upsampler_if;
  logic in_data;
  logic in_last;
  logic in_valid;
  logic in_ready;
  modport master(output in_data, in_last, in_valid, input in_ready);
  modport slave(input in_data, in_last, in_valid, output in_ready);
endinterface

// File: rtl/srrc_symbol_upsampler_sync_fifo.sv
// srrc_symbol_upsampler_sync_fifo: small show-ahead FIFO; push is refused while full
module srrc_symbol_upsampler_sync_fifo #(
  parameter int WIDTH = 2,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);
  localparam int AW = $clog2(DEPTH);
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0] count;
  logic do_push, do_pop;
  assign full    = count == (AW+1)'(DEPTH);
  assign empty   = count == '0;
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rdata   = mem[rd_ptr];
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      wr_ptr <= do_push ? wr_ptr + 1'b1 : wr_ptr;
      rd_ptr <= do_pop ? rd_ptr + 1'b1 : rd_ptr;
      count  <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  always_ff @(posedge clk)
    if (do_push) mem[wr_ptr] <= wdata;
endmodule

// File: rtl/srrc_symbol_upsampler.sv
// srrc_symbol_upsampler: buffers serial bits, maps to BPSK symbols, zero-stuffs by OSR
// and appends a zero-flush tail so the downstream SRRC filter drains after each burst.
module srrc_symbol_upsampler
  import srrc_symbol_upsampler_pkg::*;
#(
  parameter int OSR        = 4,
  parameter int FIFO_DEPTH = 4,
  parameter int FLUSH_LEN  = 32
) (
  input  logic                   clk,
  input  logic                   reset,
  srrc_symbol_upsampler_if.slave src,
  output logic [1:0]             Dout,
  output logic                   sym_strobe,
  output logic                   busy,
  output logic                   underflow
);
  localparam int PW = $clog2(OSR);
  localparam int FW = $clog2(FLUSH_LEN);
  state_t state;
  logic [PW-1:0] phase, phase_nx;
  logic [FW-1:0] flush_cnt;
  logic last_pending, full, empty, pop, slot;
  logic [1:0] head;
  assign src.in_ready = !full;
  assign phase_nx     = phase + 1'b1;
  assign slot         = state == RUN && phase_nx == '0;
  assign pop          = !empty && (state == IDLE || (slot && !last_pending));
  srrc_symbol_upsampler_sync_fifo #(.WIDTH(2), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (src.in_valid),
    .pop   (pop),
    .wdata ({src.in_last, src.in_data}),
    .rdata (head),
    .full  (full),
    .empty (empty)
  );
  // head is {last, data}; symbol slot outputs default to zero every edge
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      state        <= IDLE;
      phase        <= '0;
      flush_cnt    <= '0;
      last_pending <= 1'b0;
      Dout         <= SYM_ZERO;
      sym_strobe   <= 1'b0;
      busy         <= 1'b0;
      underflow    <= 1'b0;
    end else begin
      Dout       <= SYM_ZERO;
      sym_strobe <= 1'b0;
      underflow  <= 1'b0;
      case (state)
        IDLE: begin
          phase <= '0;
          if (!empty) begin
            state        <= RUN;
            busy         <= 1'b1;
            Dout         <= map_sym(head[0]);
            sym_strobe   <= 1'b1;
            last_pending <= head[1];
          end
        end
        RUN: begin
          phase <= phase_nx;
          if (slot) begin
            sym_strobe <= !last_pending;
            if (last_pending) begin
              state        <= FLUSH;
              flush_cnt    <= FW'(FLUSH_LEN - 1);
              last_pending <= 1'b0;
            end else if (!empty) begin
              Dout         <= map_sym(head[0]);
              last_pending <= head[1];
            end else
              underflow <= 1'b1;
          end
        end
        default: begin
          flush_cnt <= flush_cnt == '0 ? '0 : flush_cnt - 1'b1;
          if (flush_cnt == '0) begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        end
      endcase
    end
endmodule
